// File: rtl/alu_operand_collector.sv
// Operand collector in front of the 64-bit ALU: gathers up to three sources through one RF read port.
// Optional macro ALU_COLLECT_BYPASS_EN forwards the last written-back result instead of reading it.
module alu_operand_collector #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned RIDX_W = 5,
  parameter int unsigned OP_W   = 5,
  parameter int unsigned IMM_W  = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_operation,
  input  logic [RIDX_W-1:0] in_src0,
  input  logic [RIDX_W-1:0] in_src1,
  input  logic [RIDX_W-1:0] in_src2,
  input  logic [2:0]        in_src_used,
  input  logic [IMM_W-1:0]  in_immediate,
  input  logic [RIDX_W-1:0] in_dest,
  output logic              rf_rd_en,
  output logic [RIDX_W-1:0] rf_rd_addr,
  input  logic [XLEN-1:0]   rf_rd_data,
  output logic [OP_W-1:0]   alu_operation,
  output logic [XLEN-1:0]   alu_inputs_0,
  output logic [XLEN-1:0]   alu_inputs_1,
  output logic [XLEN-1:0]   alu_inputs_2,
  output logic [IMM_W-1:0]  alu_immediate,
  input  logic [XLEN-1:0]   alu_output_0,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RIDX_W-1:0] wb_dest,
  output logic [XLEN-1:0]   wb_data
);

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StExec, StWb} state_e;

  state_e              state_q, state_d;
  logic [2:0]          pend_q;
  logic [RIDX_W-1:0]   src0_q, src1_q, src2_q, dest_q;
  logic                cap_q;
  logic [1:0]          cap_idx_q;
  logic [2:0]          rd_bit;
  logic [1:0]          rd_sel;
  logic [RIDX_W-1:0]   rd_addr;
  logic                accept;
  logic [2:0]          byp_hit;
  logic [2:0]          mask_eff;
  logic [XLEN-1:0]     byp_word;

`ifdef ALU_COLLECT_BYPASS_EN
  logic              byp_valid;
  logic [RIDX_W-1:0] byp_dest;
  logic [XLEN-1:0]   byp_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byp_valid <= 1'b0;
      byp_dest  <= '0;
      byp_data  <= '0;
    end else if (state_q == StWb && wb_ready) begin
      byp_valid <= 1'b1;
      byp_dest  <= wb_dest;
      byp_data  <= wb_data;
    end
  end

  // Hits are resolved at accept; nothing can write back while an instruction is in flight.
  always_comb begin
    byp_hit[0] = byp_valid && in_src_used[0] && (in_src0 == byp_dest);
    byp_hit[1] = byp_valid && in_src_used[1] && (in_src1 == byp_dest);
    byp_hit[2] = byp_valid && in_src_used[2] && (in_src2 == byp_dest);
  end
  assign byp_word = byp_data;
`else
  assign byp_hit  = 3'b000;
  assign byp_word = '0;
`endif

  assign mask_eff = in_src_used & ~byp_hit;
  assign accept   = in_valid && (state_q == StIdle);
  assign in_ready = (state_q == StIdle);
  assign wb_valid = (state_q == StWb);

  // Lowest pending source goes first.
  always_comb begin
    rd_bit  = 3'b000;
    rd_sel  = 2'd0;
    rd_addr = '0;
    if (pend_q[0]) begin
      rd_bit  = 3'b001;
      rd_sel  = 2'd0;
      rd_addr = src0_q;
    end else if (pend_q[1]) begin
      rd_bit  = 3'b010;
      rd_sel  = 2'd1;
      rd_addr = src1_q;
    end else if (pend_q[2]) begin
      rd_bit  = 3'b100;
      rd_sel  = 2'd2;
      rd_addr = src2_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) state_d = (|mask_eff) ? StRead : StExec;
      end
      StRead: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = rd_addr;
        if ((pend_q & ~rd_bit) == 3'b000) state_d = StDrain;
      end
      StDrain: state_d = StExec;
      StExec:  state_d = StWb;
      StWb: begin
        if (wb_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pend_q        <= 3'b000;
      src0_q        <= '0;
      src1_q        <= '0;
      src2_q        <= '0;
      dest_q        <= '0;
      cap_q         <= 1'b0;
      cap_idx_q     <= 2'd0;
      alu_operation <= '0;
      alu_inputs_0  <= '0;
      alu_inputs_1  <= '0;
      alu_inputs_2  <= '0;
      alu_immediate <= '0;
      wb_dest       <= '0;
      wb_data       <= '0;
    end else begin
      state_q   <= state_d;
      cap_q     <= rf_rd_en;
      cap_idx_q <= rd_sel;
      if (accept) begin
        alu_operation <= in_operation;
        alu_immediate <= in_immediate;
        dest_q        <= in_dest;
        src0_q        <= in_src0;
        src1_q        <= in_src1;
        src2_q        <= in_src2;
        pend_q        <= mask_eff;
        alu_inputs_0  <= byp_hit[0] ? byp_word : '0;
        alu_inputs_1  <= byp_hit[1] ? byp_word : '0;
        alu_inputs_2  <= byp_hit[2] ? byp_word : '0;
      end else if (state_q == StRead) begin
        pend_q <= pend_q & ~rd_bit;
      end
      if (cap_q) begin
        unique case (cap_idx_q)
          2'd0:    alu_inputs_0 <= rf_rd_data;
          2'd1:    alu_inputs_1 <= rf_rd_data;
          default: alu_inputs_2 <= rf_rd_data;
        endcase
      end
      if (state_q == StExec) begin
        wb_data <= alu_output_0;
        wb_dest <= dest_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector with a registered regfile and a tiny ALU model.
module tb_alu_operand_collector;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_operation = '0;
  logic [4:0]  in_src0 = '0, in_src1 = '0, in_src2 = '0;
  logic [2:0]  in_src_used = '0;
  logic [16:0] in_immediate = '0;
  logic [4:0]  in_dest = '0;
  logic        rf_rd_en;
  logic [4:0]  rf_rd_addr;
  logic [63:0] rf_rd_data = '0;
  logic [4:0]  alu_operation;
  logic [63:0] alu_inputs_0, alu_inputs_1, alu_inputs_2;
  logic [16:0] alu_immediate;
  logic [63:0] alu_output_0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_dest;
  logic [63:0] wb_data;

  alu_operand_collector dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_operation(in_operation), .in_src0(in_src0), .in_src1(in_src1), .in_src2(in_src2),
    .in_src_used(in_src_used), .in_immediate(in_immediate), .in_dest(in_dest),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .alu_operation(alu_operation), .alu_inputs_0(alu_inputs_0), .alu_inputs_1(alu_inputs_1),
    .alu_inputs_2(alu_inputs_2), .alu_immediate(alu_immediate), .alu_output_0(alu_output_0),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  logic [63:0] rf [32];
  always @(posedge clock) if (rf_rd_en) rf_rd_data <= rf[rf_rd_addr];

  // Toy ALU: AND, masked shift, sum, and pass-through of input 0.
  logic [3:0] sh;
  always_comb begin
    sh = alu_immediate[4:1];
    case (alu_operation)
      5'b00011: alu_output_0 = alu_inputs_0 & alu_inputs_1;
      5'b01001: alu_output_0 = ((alu_inputs_1 << sh) >> sh) | alu_inputs_0 | alu_inputs_2;
      5'b00100: alu_output_0 = alu_inputs_0 + alu_inputs_1 + alu_inputs_2 + 64'(alu_immediate);
      default:  alu_output_0 = alu_inputs_0;
    endcase
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          wb_rel;
  int          n_rd;
  int          rd_rel [4];
  logic [4:0]  rd_addr [4];
  logic [63:0] got_data;
  logic [4:0]  got_dest;

  task automatic issue(input logic [4:0] op, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] mask, input logic [16:0] imm,
                       input logic [4:0] dest);
    @(negedge clock);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_operation = op; in_src0 = s0; in_src1 = s1; in_src2 = s2;
    in_src_used = mask; in_immediate = imm; in_dest = dest;
    in_valid = 1'b1;
  endtask

  task automatic collect(input int hold);
    logic busy_ready = 1'b0;
    wb_rel   = 0;
    n_rd     = 0;
    wb_ready = (hold == 0);
    for (int rel = 1; rel <= 30 && wb_rel == 0; rel++) begin
      @(negedge clock);
      in_valid = 1'b0;
      if (in_ready) busy_ready = 1'b1;
      if (rf_rd_en) begin
        if (n_rd < 4) begin
          rd_rel[n_rd]  = rel;
          rd_addr[n_rd] = rf_rd_addr;
        end
        n_rd++;
      end
      if (wb_valid) wb_rel = rel;
    end
    check("in_ready_busy", 64'(busy_ready), 64'd0);
    if (wb_rel == 0) begin
      check("wb_timeout", 64'd0, 64'd1);
    end else begin
      got_data = wb_data;
      got_dest = wb_dest;
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        check("hold_valid", 64'(wb_valid), 64'd1);
        check("hold_data", wb_data, got_data);
        check("hold_dest", 64'(wb_dest), 64'(got_dest));
        check("hold_ready", 64'(in_ready), 64'd0);
      end
      wb_ready = 1'b1;
      @(negedge clock);
      check("back_idle", 64'(in_ready), 64'd1);
      check("wb_drop", 64'(wb_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'h0;
    rf[1] = 64'hFF00; rf[2] = 64'h0FF0; rf[3] = 64'h1; rf[4] = 64'h0;
    rf[5] = 64'h1234; rf[9] = 64'h5555; rf[10] = 64'hABCD;

    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_rd_en", 64'(rf_rd_en), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_alu_op", 64'(alu_operation), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Two sources, AND.
    issue(5'b00011, 5'd1, 5'd2, 5'd0, 3'b011, 17'd0, 5'd7);
    collect(0);
    check("t1_nrd", 64'(n_rd), 64'd2);
    check("t1_rd0_rel", 64'(rd_rel[0]), 64'd1);
    check("t1_rd0_addr", 64'(rd_addr[0]), 64'd1);
    check("t1_rd1_rel", 64'(rd_rel[1]), 64'd2);
    check("t1_rd1_addr", 64'(rd_addr[1]), 64'd2);
    check("t1_wb_rel", 64'(wb_rel), 64'd5);
    check("t1_wb_data", got_data, 64'h0F00);
    check("t1_wb_dest", 64'(got_dest), 64'd7);
    check("t1_in0", alu_inputs_0, 64'hFF00);
    check("t1_in1", alu_inputs_1, 64'h0FF0);
    check("t1_in2", alu_inputs_2, 64'h0);
    check("t1_op", 64'(alu_operation), 64'd3);

    // Three sources, shift op.
    issue(5'b01001, 5'd4, 5'd3, 5'd4, 3'b111, 17'h4, 5'd6);
    collect(0);
    check("t2_nrd", 64'(n_rd), 64'd3);
    check("t2_rd2_rel", 64'(rd_rel[2]), 64'd3);
    check("t2_rd0_addr", 64'(rd_addr[0]), 64'd4);
    check("t2_rd1_addr", 64'(rd_addr[1]), 64'd3);
    check("t2_rd2_addr", 64'(rd_addr[2]), 64'd4);
    check("t2_wb_rel", 64'(wb_rel), 64'd6);
    check("t2_wb_data", got_data, 64'h1);
    check("t2_imm", 64'(alu_immediate), 64'h4);
    check("t2_in1", alu_inputs_1, 64'h1);

    // No sources: operands cleared, no reads.
    issue(5'b00100, 5'd1, 5'd2, 5'd3, 3'b000, 17'd0, 5'd12);
    collect(0);
    check("t3_nrd", 64'(n_rd), 64'd0);
    check("t3_wb_rel", 64'(wb_rel), 64'd2);
    check("t3_wb_data", got_data, 64'h0);
    check("t3_in1_clr", alu_inputs_1, 64'h0);

    // Writeback backpressure.
    issue(5'b00011, 5'd1, 5'd2, 5'd0, 3'b011, 17'd0, 5'd13);
    collect(5);
    check("t4_wb_data", got_data, 64'h0F00);
    check("t4_wb_dest", 64'(got_dest), 64'd13);

    // Reset in READ after the first read.
    issue(5'b00011, 5'd1, 5'd2, 5'd0, 3'b011, 17'd0, 5'd7);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rr_in_ready", 64'(in_ready), 64'd1);
    check("rr_rd_en", 64'(rf_rd_en), 64'd0);
    check("rr_rd_addr", 64'(rf_rd_addr), 64'd0);
    check("rr_in0", alu_inputs_0, 64'h0);
    check("rr_op", 64'(alu_operation), 64'd0);
    check("rr_wb_data", wb_data, 64'h0);
    check("rr_wb_dest", 64'(wb_dest), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    issue(5'b00000, 5'd5, 5'd0, 5'd0, 3'b001, 17'd0, 5'd14);
    collect(0);
    check("t5_wb_rel", 64'(wb_rel), 64'd4);
    check("t5_wb_data", got_data, 64'h1234);

`ifdef ALU_COLLECT_BYPASS_EN
    issue(5'b00000, 5'd10, 5'd0, 5'd0, 3'b001, 17'd0, 5'd9);
    collect(0);
    check("t6_seed", got_data, 64'hABCD);
    issue(5'b00000, 5'd9, 5'd0, 5'd0, 3'b001, 17'd0, 5'd15);
    collect(0);
    check("t6_nrd", 64'(n_rd), 64'd0);
    check("t6_wb_rel", 64'(wb_rel), 64'd2);
    check("t6_wb_data", got_data, 64'hABCD);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
